top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 58 +++++
 tb/tb_top.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/top.sv
// Accumulating table walker: C[index] += A[index] + B[index] on each enabled
// clock, with A/B constant operand tables loaded by the async reset.
module top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic [7:0]  index,
  output logic [31:0] sum
);

  logic [7:0]  r_index;
  logic [31:0] w_a [256];
  logic [31:0] w_b [256];
  logic [31:0] w_c [256];
  logic [7:0]  w_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index <= 8'd0;
    end else if (run) begin
      r_index <= r_index + 8'd1;
    end
  end

  // One register set per table entry; only the addressed C entry is written.
  for (genvar g = 0; g < 256; g++) begin : g_ent
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_c;
    logic        w_we;

    assign w_we = run && (r_index == 8'(g));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_a <= 32'(g);
        r_b <= 32'(3 * g);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_c <= 32'd0;
      end else if (w_we) begin
        r_c <= r_c + r_a + r_b;
      end
    end

    assign w_a[g] = r_a;
    assign w_b[g] = r_b;
    assign w_c[g] = r_c;
  end

  assign w_prev = r_index - 8'd1;
  assign index  = r_index;
  assign sum    = w_c[w_prev];

endmodule

// File: tb/tb_top.sv
// Directed bench for top: reset, full sweep with wrap, stall, async reset,
// and a randomized run pattern checked against a second instance and a model.
module tb_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  index, index2;
  logic [31:0] sum, sum2;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  top u_dut  (.clk(clk), .rst_n(rst_n), .run(run), .index(index),  .sum(sum));
  top u_twin (.clk(clk), .rst_n(rst_n), .run(run), .index(index2), .sum(sum2));

  // Drive run at a negedge, let one rising edge happen, return at next negedge.
  task automatic tick(input logic r);
    run = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    run   = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run   = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (index !== 8'd0) begin
      n_bad++; $display("FAIL reset_index got %0d want 0", index);
    end
    n_cmp++;
    if (sum !== 32'd0) begin
      n_bad++; $display("FAIL reset_sum got %h want 00000000", sum);
    end
    run   = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1'b0);
      n_cmp++;
      if (index !== 8'd0 || sum !== 32'd0) begin
        n_bad++; $display("FAIL idle_hold cyc %0d got idx=%0d sum=%h want idx=0 sum=0", k, index, sum);
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0]  exp_idx;
    logic [31:0] exp_sum;
    apply_reset();
    for (int k = 1; k <= 256; k++) begin
      tick(1'b1);
      exp_idx = 8'(k);
      exp_sum = 32'(4 * (k - 1));
      n_cmp++;
      if (index !== exp_idx || sum !== exp_sum) begin
        n_bad++; $display("FAIL sweep n=%0d got idx=%0d sum=%h want idx=%0d sum=%h", k, index, sum, exp_idx, exp_sum);
      end
    end
    n_cmp++;
    if (sum !== 32'h0000_03FC) begin
      n_bad++; $display("FAIL sweep_wrap_sum got %h want 000003fc", sum);
    end
    tick(1'b1);
    n_cmp++;
    if (index !== 8'd1 || sum !== 32'd0) begin
      n_bad++; $display("FAIL wrap_257 got idx=%0d sum=%h want idx=1 sum=0", index, sum);
    end
    tick(1'b1);
    n_cmp++;
    if (index !== 8'd2 || sum !== 32'd8) begin
      n_bad++; $display("FAIL wrap_258 got idx=%0d sum=%h want idx=2 sum=8", index, sum);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    repeat (5) tick(1'b1);
    n_cmp++;
    if (index !== 8'd5 || sum !== 32'd16) begin
      n_bad++; $display("FAIL stall_pre got idx=%0d sum=%0d want idx=5 sum=16", index, sum);
    end
    for (int k = 0; k < 3; k++) begin
      tick(1'b0);
      n_cmp++;
      if (index !== 8'd5 || sum !== 32'd16) begin
        n_bad++; $display("FAIL stall_hold cyc %0d got idx=%0d sum=%0d want idx=5 sum=16", k, index, sum);
      end
    end
    tick(1'b1);
    n_cmp++;
    if (index !== 8'd6 || sum !== 32'd20) begin
      n_bad++; $display("FAIL stall_post got idx=%0d sum=%0d want idx=6 sum=20", index, sum);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (37) tick(1'b1);
    n_cmp++;
    if (index !== 8'd37 || sum !== 32'd144) begin
      n_bad++; $display("FAIL pre_async got idx=%0d sum=%0d want idx=37 sum=144", index, sum);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (clk !== 1'b0 || index !== 8'd0 || sum !== 32'd0) begin
      n_bad++; $display("FAIL async_clear got clk=%b idx=%0d sum=%0d want clk=0 idx=0 sum=0", clk, index, sum);
    end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1'b1);
      n_cmp++;
      if (index !== 8'(k) || sum !== 32'(4 * (k - 1))) begin
        n_bad++; $display("FAIL post_async n=%0d got idx=%0d sum=%0d want idx=%0d sum=%0d", k, index, sum, k, 4 * (k - 1));
      end
    end
  endtask

  task automatic test_twin();
    logic [31:0] mc [256];
    logic [7:0]  midx;
    logic        r;
    apply_reset();
    for (int i = 0; i < 256; i++) mc[i] = 32'd0;
    midx = 8'd0;
    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(0, 3) != 0);
      tick(r);
      if (r) begin
        mc[midx] = mc[midx] + 32'(4 * int'(midx));
        midx     = midx + 8'd1;
      end
      n_cmp++;
      if (index !== index2 || sum !== sum2) begin
        n_bad++; $display("FAIL twin cyc %0d got idx=%0d sum=%h twin idx=%0d sum=%h", k, index, sum, index2, sum2);
      end
      n_cmp++;
      if (index !== midx || sum !== mc[8'(midx - 8'd1)]) begin
        n_bad++; $display("FAIL model cyc %0d got idx=%0d sum=%h want idx=%0d sum=%h", k, index, sum, midx, mc[8'(midx - 8'd1)]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_stall();
    test_async_reset();
    test_twin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
